// File: rtl/master_msg_rx.sv
// Master-side receiver for the inter-FPGA slave message link.
// Generates MSG_CLK, samples the framed 4-lane uplink mid-bit and rebuilds
// the byte stream with SOF/EOF/byte-count/error indications.
`timescale 1ns/1ps
module master_msg_rx #(
  parameter int CLK_DIV   = 4,
  parameter int MAX_BYTES = 4096
) (
  input  logic        clk_sys_i,
  input  logic        rst_i,
  output logic        msg_clk_o,
  input  logic        msg_tx_fsx_i,
  input  logic [3:0]  msg_tx_i,
  output logic        rx_data_vld_o,
  output logic [7:0]  rx_data_o,
  output logic        rx_sof_o,
  output logic        rx_eof_o,
  output logic [15:0] rx_byte_cnt_o,
  output logic        frame_err_o
);

  localparam logic [7:0]  DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [15:0] MAX_CNT  = 16'(MAX_BYTES);

  typedef enum logic [2:0] {
    WAIT_IDLE = 3'd0,
    IDLE      = 3'd1,
    LO_NIB    = 3'd2,
    HI_NIB    = 3'd3,
    DISCARD   = 3'd4
  } state_t;

  logic [7:0] div_cnt;
  logic       strobe;
  logic       fsx_p0;
  logic [3:0] lane_p0;
  logic [3:0] hi_nib;
  state_t     state;
  state_t     state_nxt;
  logic       vld_nxt;
  logic       sof_nxt;
  logic       eof_nxt;
  logic       err_nxt;
  logic       hi_ld;
  logic       cnt_clr;
  logic       cnt_inc;

  // Byte count never runs past the frame limit.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v >= MAX_CNT) ? MAX_CNT : v + 16'd1;
  endfunction

  // Link clock divider: toggle MSG_CLK every CLK_DIV system cycles.
  always_ff @(posedge clk_sys_i) begin
    if (rst_i) begin
      div_cnt   <= 8'd0;
      msg_clk_o <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt   <= 8'd0;
      msg_clk_o <= ~msg_clk_o;
    end else begin
      div_cnt <= div_cnt + 8'd1;
    end
  end

  // Sample in the cycle MSG_CLK falls, half a bit after the slave launched.
  assign strobe = (div_cnt == DIV_LAST) && msg_clk_o;

  // ---- stage p0: input register in front of all link logic ----
  // Register the frame strobe; it steers control so it gets reset.
  always_ff @(posedge clk_sys_i) begin
    if (rst_i) fsx_p0 <= 1'b0;
    else       fsx_p0 <= msg_tx_fsx_i;
  end

  // Register the data lanes (pure data, no reset needed).
  always_ff @(posedge clk_sys_i) begin
    lane_p0 <= msg_tx_i;
  end

  // ---- stage p1: frame FSM, advanced only on the sample strobe ----
  // State register.
  always_ff @(posedge clk_sys_i) begin
    if (rst_i)       state <= WAIT_IDLE;
    else if (strobe) state <= state_nxt;
  end

  // Next-state decode from the registered frame strobe.
  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_IDLE: if (!fsx_p0) state_nxt = IDLE;
      IDLE:      if (fsx_p0)  state_nxt = LO_NIB;
      LO_NIB: begin
        if (!fsx_p0)                       state_nxt = IDLE;
        else if (rx_byte_cnt_o < MAX_CNT)  state_nxt = HI_NIB;
        else                               state_nxt = DISCARD;
      end
      HI_NIB:    state_nxt = fsx_p0 ? LO_NIB : IDLE;
      DISCARD:   if (!fsx_p0) state_nxt = IDLE;
      default:   state_nxt = WAIT_IDLE;
    endcase
  end

  // Output/action decode; everything is gated by the strobe.
  always_comb begin
    vld_nxt = 1'b0;
    sof_nxt = 1'b0;
    eof_nxt = 1'b0;
    err_nxt = 1'b0;
    hi_ld   = 1'b0;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    if (strobe) begin
      case (state)
        IDLE: if (fsx_p0) begin
          sof_nxt = 1'b1;
          hi_ld   = 1'b1;
          cnt_clr = 1'b1;
        end
        LO_NIB: begin
          if (!fsx_p0) begin
            // Odd nibble count: the half byte is dropped.
            err_nxt = 1'b1;
            eof_nxt = 1'b1;
          end else if (rx_byte_cnt_o < MAX_CNT) begin
            vld_nxt = 1'b1;
            cnt_inc = 1'b1;
          end else begin
            // Single error for the whole oversized frame; DISCARD stays quiet.
            err_nxt = 1'b1;
          end
        end
        HI_NIB: begin
          if (fsx_p0) hi_ld   = 1'b1;
          else        eof_nxt = 1'b1;
        end
        DISCARD: if (!fsx_p0) eof_nxt = 1'b1;
        default: ;
      endcase
    end
  end

  // ---- stage p2: registered outputs, one cycle after the strobe ----
  // High-nibble holding register.
  always_ff @(posedge clk_sys_i) begin
    if (hi_ld) hi_nib <= lane_p0;
  end

  // Output pulses, byte and count registers.
  always_ff @(posedge clk_sys_i) begin
    if (rst_i) begin
      rx_data_vld_o <= 1'b0;
      rx_sof_o      <= 1'b0;
      rx_eof_o      <= 1'b0;
      frame_err_o   <= 1'b0;
      rx_data_o     <= 8'd0;
      rx_byte_cnt_o <= 16'd0;
    end else begin
      rx_data_vld_o <= vld_nxt;
      rx_sof_o      <= sof_nxt;
      rx_eof_o      <= eof_nxt;
      frame_err_o   <= err_nxt;
      if (vld_nxt) rx_data_o <= {hi_nib, lane_p0};
      if (cnt_clr)      rx_byte_cnt_o <= 16'd0;
      else if (cnt_inc) rx_byte_cnt_o <= sat_inc(rx_byte_cnt_o);
    end
  end

endmodule
